dvi_serializer_n: RTL and testbench

DVI_SERIALIZER_N -- requirements
Module: dvi_serializer_n

---
 rtl/dvi_pkg.sv | 18 +
 rtl/dvi_word_fifo.sv | 61 ++++++
 rtl/dvi_serializer_n.sv | 124 ++++++++++++
 tb/tb_dvi_serializer_n.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvi_pkg.sv
// Shared definitions for the DVI serializer: TMDS control symbols, the default
// underflow filler symbol and the serializer state encoding.
package dvi_pkg;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  // Blanking symbol (C1C0 = 00) doubles as the underflow filler.
  localparam logic [9:0] DEFAULT_IDLE_WORD = CTRL_00;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/dvi_word_fifo.sv
// Small synchronous FIFO of symbol words. The read port shows the head entry
// combinationally; a pop retires it on the same edge (no prefetch register).
module dvi_word_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the registered count only, so a same-cycle pop never
  // opens a slot for a same-cycle push.
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  // NOTE: storage is deliberately not reset; the count and pointers alone
  // define which entries are valid, and resetting the array costs a reset net
  // per bit.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dvi_serializer_n.sv
// Multi-channel TMDS serializer: buffers parallel symbol words and shifts them
// out gap-free, one bit per channel per clock, with a matching clock pattern.
module dvi_serializer_n
  import dvi_pkg::*;
#(
  parameter int                NUM_CH     = 3,
  parameter int                WORD_W     = 10,
  parameter int                FIFO_DEPTH = 4,
  parameter bit                LSB_FIRST  = 1'b1,
  parameter logic [WORD_W-1:0] IDLE_WORD  = DEFAULT_IDLE_WORD
) (
  input  logic                     clk_pixel_x10,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*WORD_W-1:0] in_data,
  output logic [NUM_CH-1:0]        tmds,
  output logic                     tmds_clock,
  output logic                     running,
  output logic                     underflow,
  output logic [15:0]              underflow_count
);

  localparam int            CW       = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);
  localparam logic [CW-1:0] CLK_HIGH = CW'((WORD_W + 1) / 2);

  state_e                          state_q;
  state_e                          state_d;
  logic [CW-1:0]                   cnt_q;
  logic [NUM_CH-1:0][WORD_W-1:0]   sreg_q;
  logic [NUM_CH-1:0][WORD_W-1:0]   sreg_shifted;
  logic [NUM_CH-1:0]               emit_bits;
  logic [NUM_CH-1:0]               tmds_q;
  logic                            tmds_clock_q;
  logic                            underflow_q;
  logic [15:0]                     ucount_q;
  logic                            at_boundary;
  logic                            load;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic [NUM_CH*WORD_W-1:0]        fifo_rd_data;

  dvi_word_fifo #(
    .WIDTH(NUM_CH * WORD_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_pixel_x10),
    .rst_n    (reset_n),
    .push_i   (in_valid),
    .wr_data_i(in_data),
    .pop_i    (load),
    .rd_data_o(fifo_rd_data),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  assign in_ready = !fifo_full;

  always_ff @(posedge clk_pixel_x10 or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: the default assignment up front keeps this block free of latches.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_RUN;
      ST_RUN:  if (at_boundary && !enable) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A load happens on the enabling edge out of IDLE and on every last-bit edge.
  always_comb begin
    running     = (state_q == ST_RUN);
    at_boundary = running && (cnt_q == LAST_BIT);
    load        = enable && (!running || at_boundary);
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    if (LSB_FIRST) begin : g_lsb
      assign emit_bits[c]    = sreg_q[c][0];
      assign sreg_shifted[c] = {1'b0, sreg_q[c][WORD_W-1:1]};
    end else begin : g_msb
      assign emit_bits[c]    = sreg_q[c][WORD_W-1];
      assign sreg_shifted[c] = {sreg_q[c][WORD_W-2:0], 1'b0};
    end
  end

  // The last bit of a symbol leaves on the same edge the next word is loaded.
  always_ff @(posedge clk_pixel_x10 or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      sreg_q       <= '0;
      tmds_q       <= '0;
      tmds_clock_q <= 1'b0;
      underflow_q  <= 1'b0;
      ucount_q     <= '0;
    end else begin
      underflow_q  <= load && fifo_empty;
      tmds_q       <= running ? emit_bits : '0;
      tmds_clock_q <= running && (cnt_q < CLK_HIGH);
      if (load && fifo_empty && (ucount_q != 16'hFFFF)) begin
        ucount_q <= ucount_q + 16'd1;
      end
      if (load) begin
        cnt_q  <= '0;
        sreg_q <= fifo_empty ? {NUM_CH{IDLE_WORD}} : fifo_rd_data;
      end else if (running) begin
        cnt_q  <= at_boundary ? '0 : cnt_q + 1'b1;
        sreg_q <= sreg_shifted;
      end
    end
  end

  assign tmds            = tmds_q;
  assign tmds_clock      = tmds_clock_q;
  assign underflow       = underflow_q;
  assign underflow_count = ucount_q;

endmodule

// File: tb/tb_dvi_serializer_n.sv
// Self-checking bench for dvi_serializer_n: directed table, hand-written
// corner sequences, and random traffic against a queue-based bit-stream model.
module tb_dvi_serializer_n;

  localparam int NCH   = 3;
  localparam int WW    = 10;
  localparam int DEPTH = 4;
  localparam int HALF  = 5;
  localparam int DW    = NCH * WW;
  localparam logic [WW-1:0] IDLE_SYM = 10'b1101010100;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           enable = 1'b0;
  logic           in_valid = 1'b0;
  logic [DW-1:0]  in_data = '0;
  logic           in_ready;
  logic [NCH-1:0] tmds;
  logic           tmds_clock;
  logic           running;
  logic           underflow;
  logic [15:0]    underflow_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dvi_serializer_n dut (
    .clk_pixel_x10  (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .tmds           (tmds),
    .tmds_clock     (tmds_clock),
    .running        (running),
    .underflow      (underflow),
    .underflow_count(underflow_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue of words, output as a queue of bit slots.
  typedef struct packed {
    logic [NCH-1:0] t;
    logic           c;
  } slot_t;

  logic [DW-1:0]  fifo_m[$];
  slot_t          slots_m[$];
  bit             running_m;
  logic [NCH-1:0] tmds_m;
  logic           tclk_m;
  logic           uf_m;
  logic [15:0]    ucnt_m;

  task automatic model_reset();
    fifo_m.delete();
    slots_m.delete();
    running_m = 1'b0;
    tmds_m    = '0;
    tclk_m    = 1'b0;
    uf_m      = 1'b0;
    ucnt_m    = '0;
  endtask

  task automatic model_edge(input logic en, input logic vld, input logic [DW-1:0] d);
    bit            last_slot;
    bit            was_empty;
    bit            was_full;
    logic [DW-1:0] w;
    slot_t         s;
    last_slot = running_m && (slots_m.size() == 1);
    was_empty = (fifo_m.size() == 0);
    was_full  = (fifo_m.size() >= DEPTH);
    if (running_m && slots_m.size() > 0) begin
      s      = slots_m.pop_front();
      tmds_m = s.t;
      tclk_m = s.c;
    end else begin
      tmds_m = '0;
      tclk_m = 1'b0;
    end
    uf_m = 1'b0;
    if (en && (!running_m || last_slot)) begin
      if (was_empty) begin
        w    = {NCH{IDLE_SYM}};
        uf_m = 1'b1;
        if (ucnt_m != 16'hFFFF) ucnt_m = ucnt_m + 16'd1;
      end else begin
        w = fifo_m.pop_front();
      end
      for (int i = 0; i < WW; i++) begin
        s.c = (i < HALF);
        for (int ch = 0; ch < NCH; ch++) s.t[ch] = w[ch*WW + i];
        slots_m.push_back(s);
      end
      running_m = 1'b1;
    end else if (last_slot) begin
      running_m = 1'b0;
    end
    if (vld && !was_full) fifo_m.push_back(d);
  endtask

  task automatic step(input logic en, input logic vld, input logic [DW-1:0] d);
    enable   = en;
    in_valid = vld;
    in_data  = d;
    model_edge(en, vld, d);
    @(posedge clk);
    #1;
    check("tmds",            32'(tmds),            32'(tmds_m));
    check("tmds_clock",      32'(tmds_clock),      32'(tclk_m));
    check("running",         32'(running),         32'(running_m));
    check("underflow",       32'(underflow),       32'(uf_m));
    check("underflow_count", 32'(underflow_count), 32'(ucnt_m));
    check("in_ready",        32'(in_ready),        32'(fifo_m.size() < DEPTH));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tmds"},       32'(tmds),            32'd0);
    check({tag, "_tmds_clock"}, 32'(tmds_clock),      32'd0);
    check({tag, "_running"},    32'(running),         32'd0);
    check({tag, "_underflow"},  32'(underflow),       32'd0);
    check({tag, "_ucount"},     32'(underflow_count), 32'd0);
    check({tag, "_in_ready"},   32'(in_ready),        32'd1);
  endtask

  typedef struct {
    logic           en;
    logic           vld;
    logic [DW-1:0]  d;
    logic [NCH-1:0] t;
    logic           c;
    logic           run;
    logic           rdy;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic vld, input logic [DW-1:0] d,
                              input logic [NCH-1:0] t, input logic c, input logic run,
                              input logic rdy);
    vec_t v;
    v.en = en; v.vld = vld; v.d = d; v.t = t; v.c = c; v.run = run; v.rdy = rdy;
    return v;
  endfunction

  initial begin
    vec_t           vecs[13];
    logic [DW-1:0]  wa, wb, wc, wx, wy;
    logic [DW-1:0]  w5[5];
    logic [WW*3-1:0] cap[NCH];
    logic [WW*3-1:0] exp_bits;
    logic [DW-1:0]  wsel;
    logic [15:0]    uc0;
    int             run_hi;
    int             pulses;

    // Word 0000011111 on ch0, enable, then let enable drop at the last bit.
    vecs[0]  = mk(1'b0, 1'b1, DW'(10'b0000011111), 3'b000, 1'b0, 1'b0, 1'b1);
    vecs[1]  = mk(1'b1, 1'b0, '0, 3'b000, 1'b0, 1'b1, 1'b1);
    for (int i = 2; i <= 6; i++)  vecs[i] = mk(1'b1, 1'b0, '0, 3'b001, 1'b1, 1'b1, 1'b1);
    for (int i = 7; i <= 10; i++) vecs[i] = mk(1'b1, 1'b0, '0, 3'b000, 1'b0, 1'b1, 1'b1);
    vecs[11] = mk(1'b0, 1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b1);
    vecs[12] = mk(1'b0, 1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b1);

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("init");
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].en, vecs[i].vld, vecs[i].d);
      check($sformatf("tbl%0d_tmds", i),    32'(tmds),       32'(vecs[i].t));
      check($sformatf("tbl%0d_clock", i),   32'(tmds_clock), 32'(vecs[i].c));
      check($sformatf("tbl%0d_running", i), 32'(running),    32'(vecs[i].run));
      check($sformatf("tbl%0d_ready", i),   32'(in_ready),   32'(vecs[i].rdy));
    end

    // Three words back-to-back: 30 contiguous bits per channel.
    wa = DW'($urandom());
    wb = DW'($urandom());
    wc = DW'($urandom());
    step(1'b0, 1'b1, wa);
    step(1'b0, 1'b1, wb);
    step(1'b0, 1'b1, wc);
    run_hi = 0;
    for (int ch = 0; ch < NCH; ch++) cap[ch] = '0;
    for (int i = 0; i < 31; i++) begin
      step(1'b1, 1'b0, '0);
      if (i >= 1) for (int ch = 0; ch < NCH; ch++) cap[ch][i-1] = tmds[ch];
      if (i < 30 && running) run_hi++;
    end
    check("b2b_running_cycles", 32'(run_hi), 32'd30);
    for (int ch = 0; ch < NCH; ch++) begin
      for (int k = 0; k < 30; k++) begin
        wsel = (k < 10) ? wa : ((k < 20) ? wb : wc);
        exp_bits[k] = wsel[ch*WW + (k % WW)];
      end
      check($sformatf("b2b_stream_ch%0d", ch), 32'(cap[ch]), 32'(exp_bits));
    end
    repeat (12) step(1'b0, 1'b0, '0);

    // Empty FIFO while running: one underflow per symbol.
    uc0    = underflow_count;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b0, '0);
      if (underflow) pulses++;
    end
    check("uf_pulses", 32'(pulses), 32'd3);
    check("uf_count_delta", 32'(16'(underflow_count - uc0)), 32'd3);
    repeat (3) step(1'b1, 1'b0, '0);

    // Asynchronous reset mid-symbol.
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(1'b0, 1'b0, '0);
    check("post_rst_ready", 32'(in_ready), 32'd1);
    check("post_rst_ucount", 32'(underflow_count), 32'd0);

    // Five pushes into a four-deep FIFO with no pops.
    for (int i = 0; i < 5; i++) begin
      w5[i] = DW'($urandom());
      step(1'b0, 1'b1, w5[i]);
      check($sformatf("fill%0d_ready", i), 32'(in_ready), 32'(i < 3));
    end
    repeat (45) step(1'b1, 1'b0, '0);
    repeat (12) step(1'b0, 1'b0, '0);

    // Drop enable mid-symbol; the queued word waits for re-enable.
    wx = DW'($urandom());
    wy = DW'($urandom());
    step(1'b0, 1'b1, wx);
    step(1'b0, 1'b1, wy);
    repeat (4)  step(1'b1, 1'b0, '0);
    repeat (10) step(1'b0, 1'b0, '0);
    check("drop_running", 32'(running), 32'd0);
    check("drop_tmds", 32'(tmds), 32'd0);
    check("drop_queued", 32'(fifo_m.size()), 32'd1);
    repeat (12) step(1'b1, 1'b0, '0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)), DW'($urandom()));
    end
    repeat (12) step(1'b0, 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
